// File: rtl/nv_ram_fifo_ctrl_64x116.sv
// Control logic for a 64-entry x 116-bit FIFO built on an external RAM with a registered read address.
// The entry presented on rd_pd stays counted until it is popped, so a write can never overwrite it.
module nv_ram_fifo_ctrl_64x116 #(
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_pvld,
    output logic         wr_prdy,
    input  logic [115:0] wr_pd,
    output logic         rd_pvld,
    input  logic         rd_prdy,
    output logic [115:0] rd_pd,
    output logic [5:0]   ram_wa,
    output logic         ram_we,
    output logic [115:0] ram_di,
    output logic [5:0]   ram_ra,
    output logic         ram_re,
    input  logic [115:0] ram_dout,
    output logic [6:0]   count,
    input  logic [31:0]  pwrbus_ram_pd,
    output logic [31:0]  pwrbus_ram_pd_o
);

    logic [5:0] wr_ptr_q, wr_ptr_d;
    logic [5:0] rd_ptr_q, rd_ptr_d;
    logic [6:0] count_q, count_d;
    logic       out_vld_q, out_vld_d;
    logic [6:0] pending;
    logic       push;
    logic       pop;

    always_comb begin
        pending = count_q - {6'd0, out_vld_q};
        wr_prdy = !rst && (count_q < 7'(DEPTH));
        push    = wr_pvld && wr_prdy;
        rd_pvld = out_vld_q && !rst;
        pop     = rd_pvld && rd_prdy;
        // Fetch only entries already written, and only when the output slot is free or draining.
        ram_re  = (pending != 7'd0) && (!out_vld_q || rd_prdy) && !rst;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + {6'd0, push} - {6'd0, pop};
        out_vld_d = out_vld_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 6'd1;
        end
        if (ram_re) begin
            rd_ptr_d  = rd_ptr_q + 6'd1;
            out_vld_d = 1'b1;
        end else if (pop) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= 6'd0;
            rd_ptr_q  <= 6'd0;
            count_q   <= 7'd0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign ram_we          = push;
    assign ram_wa          = wr_ptr_q;
    assign ram_di          = wr_pd;
    assign ram_ra          = rd_ptr_q;
    assign rd_pd           = ram_dout;
    assign count           = count_q;
    assign pwrbus_ram_pd_o = pwrbus_ram_pd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && count_q == 7'(DEPTH)));
            assert (!(pop && !out_vld_q));
        end
    end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_64x116.sv
// Scoreboard bench for nv_ram_fifo_ctrl_64x116 with a behavioural RAM (registered read address).
module tb_nv_ram_fifo_ctrl_64x116;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_pvld;
    logic         wr_prdy;
    logic [115:0] wr_pd;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [115:0] rd_pd;
    logic [5:0]   ram_wa;
    logic         ram_we;
    logic [115:0] ram_di;
    logic [5:0]   ram_ra;
    logic         ram_re;
    logic [115:0] ram_dout;
    logic [6:0]   count;
    logic [31:0]  pwrbus_ram_pd;
    logic [31:0]  pwrbus_ram_pd_o;

    int compareCnt = 0;
    int mismatchCnt = 0;

    logic [115:0] expQ[$];
    logic [115:0] mem[64];
    logic [5:0]   raQ;
    logic [5:0]   expWa;
    logic [5:0]   expRa;
    int           unfetched;
    logic         prevStall;
    logic [115:0] prevPd;

    always #5 clk = ~clk;

    nv_ram_fifo_ctrl_64x116 #(.DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout),
        .count(count),
        .pwrbus_ram_pd(pwrbus_ram_pd), .pwrbus_ram_pd_o(pwrbus_ram_pd_o)
    );

    // RAM with registered read address; contents survive reset.
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) raQ <= ram_ra;
    end
    assign ram_dout = mem[raQ];

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compareCnt++;
        if (obs !== exp) begin
            mismatchCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [115:0] pd, input logic rp, input logic r);
        @(posedge clk);
        #1;
        wr_pvld = wv;
        wr_pd   = pd;
        rd_prdy = rp;
        rst     = r;
    endtask

    function automatic logic [115:0] rnd116();
        return {$urandom_range(1048575, 0), $urandom, $urandom, $urandom};
    endfunction

    task automatic drain();
        bit done;
        done = 0;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (count == 7'd0 && !rd_pvld) done = 1;
        end
        if (!done) checkOutput("drain_timeout", 0, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: compares every pop against the queue and tracks pointer and occupancy models.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_wr_prdy", wr_prdy, 0);
            checkOutput("rst_rd_pvld", rd_pvld, 0);
            checkOutput("rst_ram_we", ram_we, 0);
            checkOutput("rst_ram_re", ram_re, 0);
            expQ.delete();
            expWa = 6'd0;
            expRa = 6'd0;
            unfetched = 0;
            prevStall = 1'b0;
        end else begin
            checkOutput("count", count, expQ.size());
            checkOutput("wr_prdy", wr_prdy, expQ.size() < 64);
            checkOutput("ram_we", ram_we, wr_pvld && (expQ.size() < 64));
            if (prevStall) begin
                checkOutput("rd_pvld_hold", rd_pvld, 1);
                checkOutput("rd_pd_hold", rd_pd, prevPd);
            end
            if (ram_re) begin
                checkOutput("ram_ra", ram_ra, expRa);
                checkOutput("re_unwritten", unfetched > 0, 1);
            end
            if (ram_we) checkOutput("ram_wa", ram_wa, expWa);
            if (rd_pvld && rd_prdy) begin
                if (expQ.size() == 0) checkOutput("pop_empty", 1, 0);
                else checkOutput("rd_pd", rd_pd, expQ.pop_front());
            end
            if (wr_pvld && wr_prdy) expQ.push_back(wr_pd);
            if (ram_we) expWa = expWa + 6'd1;
            if (ram_re) expRa = expRa + 6'd1;
            unfetched = unfetched + int'(ram_we) - int'(ram_re);
            prevStall = rd_pvld && !rd_prdy;
            prevPd = rd_pd;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int streamPops;
        int bubbles;
        int maxCnt;
        bit seen;
        rst = 1'b1;
        wr_pvld = 1'b0;
        wr_pd = '0;
        rd_prdy = 1'b0;
        pwrbus_ram_pd = 32'hA5A5_0F0F;
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_rd_pvld", rd_pvld, 0);
        checkOutput("reset_wr_prdy", wr_prdy, 1);
        checkOutput("pwrbus", pwrbus_ram_pd_o, 32'hA5A5_0F0F);

        // Single word latency
        applyStimulus(1'b1, 116'h0_ABCD_1234, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("single_we", ram_we, 1);
        checkOutput("single_wa", ram_wa, 0);
        checkOutput("single_di", ram_di, 116'h0_ABCD_1234);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("single_re", ram_re, 1);
        checkOutput("single_ra", ram_ra, 0);
        checkOutput("single_pvld_early", rd_pvld, 0);
        checkOutput("single_count1", count, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("single_pvld", rd_pvld, 1);
        checkOutput("single_pd", rd_pd, 116'h0_ABCD_1234);
        checkOutput("single_count2", count, 1);
        checkOutput("single_re_idle", ram_re, 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("single_empty_count", count, 0);
        checkOutput("single_empty_pvld", rd_pvld, 0);
        checkOutput("single_empty_re", ram_re, 0);

        // Fill from a fresh reset so addresses start at 0
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, rnd116(), 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("fill_wa", ram_wa, i);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full_count", count, 64);
        checkOutput("full_wr_prdy", wr_prdy, 0);
        applyStimulus(1'b1, rnd116(), 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full_65th_we", ram_we, 0);
        applyStimulus(1'b1, rnd116(), 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("fullpop_wr_prdy", wr_prdy, 0);
        checkOutput("fullpop_we", ram_we, 0);
        checkOutput("fullpop_pvld", rd_pvld, 1);
        applyStimulus(1'b1, rnd116(), 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fullpop_next_prdy", wr_prdy, 1);
        checkOutput("fullpop_next_we", ram_we, 1);
        checkOutput("fullpop_next_wa", ram_wa, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fullpop_count", count, 64);
        drain();

        // Streaming with no backpressure
        streamPops = 0;
        bubbles = 0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b1, 116'(i + 32'h100), 1'b1, 1'b0);
            @(negedge clk);
            if (rd_pvld) begin seen = 1; streamPops++; end
            else if (seen) bubbles++;
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 100 && streamPops < 200; i++) begin
            @(negedge clk);
            if (rd_pvld) streamPops++;
            else if (streamPops < 200) bubbles++;
        end
        checkOutput("stream_pops", streamPops, 200);
        checkOutput("stream_bubbles", bubbles, 0);
        drain();

        // Random backpressure
        maxCnt = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(9, 0) < 7, rnd116(), $urandom_range(9, 0) < 3, 1'b0);
            @(negedge clk);
            if (int'(count) > maxCnt) maxCnt = int'(count);
        end
        checkOutput("bp_max_count", maxCnt <= 64, 1);
        drain();

        // Reset in the middle of traffic
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, rnd116(), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_count17", count, 17);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_count0", count, 0);
        checkOutput("midrst_pvld", rd_pvld, 0);
        applyStimulus(1'b1, rnd116(), 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_we", ram_we, 1);
        checkOutput("midrst_wa", ram_wa, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
        $finish;
    end

endmodule
